mux2_burst_arbiter: RTL and testbench
=====================================

# mux2_burst_arbiter

Round-robin arbiter sharing one 2-bit output channel between two requesters (A, B) through the team's 2-bit 2:1 mux. Grants whole bursts: the owner keeps the channel until it flags its last beat or hits `MAX_BURST` beats, then ownership passes to the other side. A one-entry registered output stage with valid/ready decouples the downstream consumer. Sits between two 2-bit producers and a single 2-bit sink.

## Interface
- `MAX_BURST`, default 4: maximum beats per grant before forced release; legal range 1..15.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_a`  input  1  A has a beat to offer.
- `data_a`  input  2  A beat data.
- `last_a`  input  1  current A beat ends A's burst.
- `ack_a`  output  1  A beat accepted this cycle (combinational).
- `req_b`, `data_b`, `last_b`, `ack_b`: same as A, for B.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  2  output beat data.
- `out_ready`  input  1  sink takes the beat when `out_valid` is high.
- `sel`  output  1  mux select: 1 iff state is OWN_B.
- `busy`  output  1  state is not IDLE.

## Operation
- States: IDLE, OWN_A, OWN_B. Round-robin pointer `ptr` names the last owner.
- IDLE: only one req high -> grant it. Both high -> grant the side not equal to `ptr`. None -> stay.
- `slot_free = !out_valid || out_ready`.
- In OWN_x: `ack_x = req_x && slot_free`; `ack` for the non-owner is always 0.
- On accept: `out_data <=` mux output (`data_x`), `out_valid <= 1`, `beat_cnt <= beat_cnt + 1`.
- Without accept: `out_valid <= 0` if `out_ready`, else hold. `out_data` holds while `out_valid && !out_ready`.
- Release when an accepted beat has `last_x = 1`, or when it is the `MAX_BURST`-th beat. On release:
  - `ptr <= x`, `beat_cnt <= 0`.
  - Other side's req high -> go directly to OWN_other (no idle bubble); else -> IDLE.
- Abandon: owner's `req_x` low while in OWN_x -> release with the same rules; no beat is transferred.
- A last beat and a `MAX_BURST` limit in the same cycle count as one release.
- `beat_cnt` width is 4 bits; it never exceeds `MAX_BURST`.

## Timing
- Reset values: state IDLE, `ptr` = B (so A wins the first tie), `beat_cnt` 0, `out_valid` 0, `out_data` 2'b00, `sel` 0, `busy` 0, `ack_a`/`ack_b` 0.
- Grant latency: req rises in IDLE at cycle n -> OWN at n+1 -> first `ack` at n+1 if slot free -> `out_valid` at n+2.
- Throughput: one beat per cycle while `out_ready` stays high. A handoff costs no cycle.
- `ack_x`, `sel`, `busy` are combinational from registered state plus inputs. `out_valid`/`out_data` are registered.
- Backpressure: `out_ready` low with `out_valid` high -> `ack` is 0 and the output is stable until the sink accepts.
- Reset mid-burst: next edge forces IDLE and `out_valid` 0; a pending beat is dropped.

## Structure
- Shared package (`arb_pkg`): state encoding constants IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2; beat counter width constant 4.
- One sub-module: existing `mux2to1` (2-bit 2:1), driven by `sel`, output feeds the output register.
- Top holds the FSM, `ptr`, `beat_cnt`, output register, and ack logic.

## Test plan
- Reset, then A alone with a 3-beat burst (data 1,2,3; `last` on beat 3), `out_ready` = 1 -> `ack_a` on cycles 1-3, `out_data` 1,2,3 on cycles 2-4, then IDLE.
- A and B both requesting from reset with long bursts and no `last`, `MAX_BURST` = 4 -> A gets 4 beats, B gets 4 beats with no gap, then A again; `sel` toggles 0 -> 1 -> 0.
- Backpressure: A streaming, `out_ready` low for 3 cycles with `out_data` = 2 -> `out_data` holds 2, `ack_a` = 0 for those cycles, resumes on the cycle `out_ready` returns.
- Abandon: grant B, B drops `req_b` after 1 beat while A requests -> transition to OWN_A next cycle, `ptr` = B.
- Reset mid-burst: assert `rst` at beat 2 of an A burst -> next cycle IDLE, `out_valid` 0, `out_data` 2'b00, `busy` 0.
- `MAX_BURST` = 1 with both requesting continuously -> strict A/B alternation every cycle; `last` is ignored.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the two-requester burst arbiter.
// No logic; constants only.
// Not applicable: no handshake lives here.
package arb_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    // Width of the per-grant beat counter
    localparam int BEAT_CNT_W = 4;

    // Round-robin pointer values (names the last owner)
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// 2-bit 2:1 data mux, sel=0 picks in0, sel=1 picks in1.
// Latency: purely combinational.
// Backpressure: none; the caller owns the handshake.
module mux2to1 (
    input  logic       sel,
    input  logic [1:0] in0,
    input  logic [1:0] in1,
    output logic [1:0] out
);

    // Select between the two producers
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter sharing one 2-bit channel between A and B.
// Latency: request in IDLE -> grant next cycle -> out_valid one cycle after the accept.
// Backpressure: acks drop while the one-entry output stage is full and out_ready is low.
module mux2_burst_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [1:0] data_a,
    input  logic       last_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [1:0] data_b,
    input  logic       last_b,
    output logic       ack_b,
    output logic       out_valid,
    output logic [1:0] out_data,
    input  logic       out_ready,
    output logic       sel,
    output logic       busy
);

    localparam logic [BEAT_CNT_W-1:0] MAX_BURST_C = BEAT_CNT_W'(MAX_BURST);

    logic [1:0]            state_q,     state_d;
    logic                  ptr_q,       ptr_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            out_data_q,  out_data_d;

    logic                  slot_free;
    logic                  own_req;
    logic                  own_last;
    logic                  other_req;
    logic                  accept;
    logic                  release_burst;
    logic [BEAT_CNT_W-1:0] beat_cnt_inc;
    logic [1:0]            mux_out;

    // Data path: the owner's beat goes through the shared mux into the output stage
    mux2to1 u_mux (
        .sel (sel),
        .in0 (data_a),
        .in1 (data_b),
        .out (mux_out)
    );

    // Handshake and release decode from registered state plus live inputs
    always_comb begin
        sel           = (state_q == OWN_B);
        busy          = (state_q != IDLE);
        slot_free     = !out_valid_q || out_ready;
        own_req       = sel ? req_b  : req_a;
        own_last      = sel ? last_b : last_a;
        other_req     = sel ? req_a  : req_b;
        ack_a         = (state_q == OWN_A) && req_a && slot_free;
        ack_b         = (state_q == OWN_B) && req_b && slot_free;
        accept        = ack_a || ack_b;
        beat_cnt_inc  = beat_cnt_q + 1'b1;
        // A last beat and hitting the limit together are a single release;
        // an owner dropping its request gives up the channel without a beat.
        release_burst = (accept && (own_last || (beat_cnt_inc == MAX_BURST_C)))
                     || (busy && !own_req);
    end

    // Next-state: grant in IDLE, hand off directly to a waiting peer on release
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (ptr_q == PTR_B) ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if (release_burst) begin
                    ptr_d      = sel ? PTR_B : PTR_A;
                    beat_cnt_d = '0;
                    if (other_req) begin
                        state_d = sel ? OWN_A : OWN_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_inc;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // One-entry output stage: load on accept, drain when the sink takes it
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_out;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a pending beat is dropped on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_B;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Directed bench for mux2_burst_arbiter (MAX_BURST=4 and MAX_BURST=1 instances).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Expected values are hand-derived per cycle.
module tb_mux2_burst_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, last_a, req_b, last_b, out_ready;
    logic [1:0] data_a, data_b;

    logic       ack_a, ack_b, out_valid, sel, busy;
    logic [1:0] out_data;
    logic       ack_a1, ack_b1, out_valid1, sel1, busy1;
    logic [1:0] out_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_burst_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .last_a(last_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .last_b(last_b), .ack_b(ack_b),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    mux2_burst_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .last_a(last_a), .ack_a(ack_a1),
        .req_b(req_b), .data_b(data_b), .last_b(last_b), .ack_b(ack_b1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
        .sel(sel1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
        data_a = 2'd0; data_b = 2'd0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
        data_a = 2'd0; data_b = 2'd0; out_ready = 1'b1;

        // ---- reset values ----
        do_reset();
        settle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 2'b00);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_ptr", dut.ptr_q, 1);

        // ---- A alone, 3-beat burst ----
        req_a = 1'b1; data_a = 2'd1; settle();
        check("a3_c0_ack", ack_a, 0);
        tick();
        check("a3_c1_busy", busy, 1);
        check("a3_c1_ack", ack_a, 1);
        check("a3_c1_valid", out_valid, 0);
        tick(); data_a = 2'd2; settle();
        check("a3_c2_ack", ack_a, 1);
        check("a3_c2_data", out_data, 1);
        check("a3_c2_valid", out_valid, 1);
        tick(); data_a = 2'd3; last_a = 1'b1; settle();
        check("a3_c3_ack", ack_a, 1);
        check("a3_c3_data", out_data, 2);
        tick(); req_a = 1'b0; last_a = 1'b0; settle();
        check("a3_c4_data", out_data, 3);
        check("a3_c4_valid", out_valid, 1);
        check("a3_c4_busy", busy, 0);
        check("a3_c4_ptr", dut.ptr_q, 0);
        tick();
        check("a3_c5_valid", out_valid, 0);

        // ---- both requesting, no last: 4 A beats, 4 B beats, then A ----
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 2'd1; data_b = 2'd2; settle();
        check("rr_c0_busy", busy, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("rr_c%0d_sel", k), sel, (k >= 5 && k <= 8) ? 1 : 0);
            check($sformatf("rr_c%0d_ack_a", k), ack_a, (k >= 5 && k <= 8) ? 0 : 1);
            check($sformatf("rr_c%0d_ack_b", k), ack_b, (k >= 5 && k <= 8) ? 1 : 0);
            if (k >= 2) begin
                check($sformatf("rr_c%0d_valid", k), out_valid, 1);
                check($sformatf("rr_c%0d_data", k), out_data, (k >= 6 && k <= 9) ? 2 : 1);
            end
        end

        // ---- backpressure ----
        do_reset();
        req_a = 1'b1; data_a = 2'd1;
        tick();                                   // cycle 1: beat 1
        check("bp_c1_ack", ack_a, 1);
        tick(); data_a = 2'd2; settle();          // cycle 2: beat 2
        check("bp_c2_ack", ack_a, 1);
        tick(); data_a = 2'd3;                    // cycle 3: stall starts
        for (int k = 3; k <= 5; k++) begin
            out_ready = 1'b0; settle();
            check($sformatf("bp_c%0d_ack", k), ack_a, 0);
            check($sformatf("bp_c%0d_data", k), out_data, 2);
            check($sformatf("bp_c%0d_valid", k), out_valid, 1);
            tick();
        end
        out_ready = 1'b1; settle();               // cycle 6: sink resumes
        check("bp_c6_ack", ack_a, 1);
        check("bp_c6_data", out_data, 2);
        tick();
        check("bp_c7_data", out_data, 3);
        check("bp_c7_busy", busy, 1);

        // ---- abandon: B gives up after one beat while A waits ----
        do_reset();
        req_b = 1'b1; data_b = 2'd3;
        tick();
        check("ab_c1_sel", sel, 1);
        check("ab_c1_ack_b", ack_b, 1);
        req_a = 1'b1; data_a = 2'd1; settle();
        check("ab_c1_ack_a", ack_a, 0);
        tick(); req_b = 1'b0; settle();
        check("ab_c2_data", out_data, 3);
        check("ab_c2_ack_a", ack_a, 0);
        check("ab_c2_ack_b", ack_b, 0);
        tick();
        check("ab_c3_sel", sel, 0);
        check("ab_c3_busy", busy, 1);
        check("ab_c3_ack_a", ack_a, 1);
        check("ab_c3_valid", out_valid, 0);
        check("ab_c3_ptr", dut.ptr_q, 1);

        // ---- reset in the middle of an A burst ----
        do_reset();
        req_a = 1'b1; data_a = 2'd1;
        tick();
        tick(); data_a = 2'd2; rst = 1'b1; settle();
        check("mr_c2_ack", ack_a, 1);
        tick(); rst = 1'b0; req_a = 1'b0; settle();
        check("mr_busy", busy, 0);
        check("mr_valid", out_valid, 0);
        check("mr_data", out_data, 2'b00);
        check("mr_sel", sel, 0);

        // ---- MAX_BURST=1: strict alternation, last ignored ----
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 2'd1; data_b = 2'd2; last_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("m1_c%0d_sel", k), sel1, (k % 2 == 0) ? 1 : 0);
            check($sformatf("m1_c%0d_ack_a", k), ack_a1, (k % 2 == 1) ? 1 : 0);
            check($sformatf("m1_c%0d_ack_b", k), ack_b1, (k % 2 == 0) ? 1 : 0);
            if (k >= 2) begin
                check($sformatf("m1_c%0d_data", k), out_data1, (k % 2 == 0) ? 1 : 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
